// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared definitions for the multi-cycle RV32I control path.
// Holds opcode constants, the control FSM state encoding and the datapath
// select encodings driven by mc_control_fsm.
package riscv_mc_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StJal      = 4'd8,
        StLui      = 4'd9,
        StAluWb    = 4'd10,
        StBeq      = 4'd11,
        StHalt     = 4'd12
    } state_e;

    // result_src
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    // alu_src_a
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // alu_src_b
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    // alu_op
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects, write strobes and the unified-memory handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode                instruction[6:0], sampled in DECODE and MEMADR
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_write    memory request and store qualifier
//   adr_src               memory address select (0 = PC, 1 = ALUOut)
//   ir_write, pc_update   IR/OldPC load and PC write strobes
//   reg_write             register file write enable
//   result_src            result bus select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation class
//   branch                conditional-branch strobe
//   halted                FSM is in HALT
//
// Parameter ILLEGAL_HALT: 1 = unknown opcode halts (sticky), 0 = treated as NOP.
// Macro MC_CTRL_BEQ_EN: enables the BEQ state; otherwise 1100011 is illegal
// and branch is constant 0.
module mc_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       branch,
    output logic       halted
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecR;
                    OP_I:              state_d = StExecI;
                    OP_JAL:            state_d = StJal;
                    OP_LUI:            state_d = StLui;
`ifdef MC_CTRL_BEQ_EN
                    OP_BRANCH:         state_d = StBeq;
`endif
                    default:           state_d = ILLEGAL_HALT ? StHalt : StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode == OP_LOAD) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        reg_write  = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluAdd;
        branch     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                // IR and PC load in the cycle the fetch completes.
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            StDecode: begin
                // Precompute PC-relative target into ALUOut.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResMem;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluFunct;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
            end
            StJal: begin
                // Jump target comes from ALUOut; link value OldPC+4 is computed now.
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_update  = 1'b1;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
            end
`ifdef MC_CTRL_BEQ_EN
            StBeq: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBRs2;
                alu_op     = AluSub;
                result_src = ResAluOut;
                branch     = 1'b1;
            end
`endif
            StHalt: begin
                halted = 1'b1;
            end
            default: ;
        endcase

        // Reset overrides state decode so nothing is written while rst_n is low.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_update  = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            halted     = 1'b0;
            result_src = ResAlu;
            alu_src_a  = SrcAPc;
            alu_src_b  = SrcBFour;
            alu_op     = AluAdd;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: cycle-by-cycle vector table plus hand-written
// sequences for halt, asynchronous mid-instruction reset and the branch opcode.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_update, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       branch, halted;

    mc_control_fsm #(.ILLEGAL_HALT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .branch     (branch),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, branch, halted}
    logic [15:0] got;
    assign got = {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, branch, halted};

    localparam logic [15:0] E_RST   = 16'b0_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] E_FET1  = 16'b1_0_0_1_1_0_10_00_10_00_0_0;
    localparam logic [15:0] E_FET0  = 16'b1_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] E_DEC   = 16'b0_0_0_0_0_0_00_01_01_00_0_0;
    localparam logic [15:0] E_MADR  = 16'b0_0_0_0_0_0_00_10_01_00_0_0;
    localparam logic [15:0] E_MRD   = 16'b1_0_1_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] E_MWB   = 16'b0_0_0_0_0_1_01_00_00_00_0_0;
    localparam logic [15:0] E_MWR   = 16'b1_1_1_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] E_EXR   = 16'b0_0_0_0_0_0_00_10_00_10_0_0;
    localparam logic [15:0] E_EXI   = 16'b0_0_0_0_0_0_00_10_01_10_0_0;
    localparam logic [15:0] E_JAL   = 16'b0_0_0_0_1_0_00_01_10_00_0_0;
    localparam logic [15:0] E_LUI   = 16'b0_0_0_0_0_0_00_11_01_00_0_0;
    localparam logic [15:0] E_AWB   = 16'b0_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] E_HALT  = 16'b0_0_0_0_0_0_00_00_00_00_0_1;
    localparam logic [15:0] E_BEQ   = 16'b0_0_0_0_0_0_00_10_00_01_1_0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_RR  = 7'b0110011;
    localparam logic [6:0] OP_II  = 7'b0010011;
    localparam logic [6:0] OP_JJ  = 7'b1101111;
    localparam logic [6:0] OP_LU  = 7'b0110111;
    localparam logic [6:0] OP_BQ  = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b0001111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic mr,
                                input logic [15:0] exp, input string nm);
        vec_t v;
        v.rst = r;
        v.op  = op;
        v.mr  = mr;
        v.exp = exp;
        v.nm  = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare at the falling edge, advance past the rising edge.
    task automatic cyc(input logic r, input logic [6:0] op, input logic mr,
                       input logic [15:0] exp, input string nm);
        rst_n     = r;
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        opcode    = OP_RR;
        mem_ready = 1'b1;
        #1;
        rst_n     = 1'b0;

        // Reset, then R-type with zero-wait memory
        vecs.push_back(mk(1'b0, OP_RR, 1'b1, E_RST,  "rst_c1"));
        vecs.push_back(mk(1'b0, OP_RR, 1'b1, E_RST,  "rst_c2"));
        vecs.push_back(mk(1'b0, OP_RR, 1'b1, E_RST,  "rst_c3"));
        vecs.push_back(mk(1'b1, OP_RR, 1'b1, E_FET1, "r_fetch"));
        vecs.push_back(mk(1'b1, OP_RR, 1'b1, E_DEC,  "r_decode"));
        vecs.push_back(mk(1'b1, OP_RR, 1'b1, E_EXR,  "r_execr"));
        vecs.push_back(mk(1'b1, OP_RR, 1'b1, E_AWB,  "r_aluwb"));
        // LW with two memory wait cycles: 7 cycles
        vecs.push_back(mk(1'b1, OP_LW, 1'b1, E_FET1, "lw_fetch"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b1, E_DEC,  "lw_decode"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b1, E_MADR, "lw_memadr"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b0, E_MRD,  "lw_memread_w1"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b0, E_MRD,  "lw_memread_w2"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b1, E_MRD,  "lw_memread_rdy"));
        vecs.push_back(mk(1'b1, OP_LW, 1'b1, E_MWB,  "lw_memwb"));
        // SW with a fetch wait cycle
        vecs.push_back(mk(1'b1, OP_SW, 1'b0, E_FET0, "sw_fetch_wait"));
        vecs.push_back(mk(1'b1, OP_SW, 1'b1, E_FET1, "sw_fetch"));
        vecs.push_back(mk(1'b1, OP_SW, 1'b1, E_DEC,  "sw_decode"));
        vecs.push_back(mk(1'b1, OP_SW, 1'b1, E_MADR, "sw_memadr"));
        vecs.push_back(mk(1'b1, OP_SW, 1'b1, E_MWR,  "sw_memwrite"));
        // I-type
        vecs.push_back(mk(1'b1, OP_II, 1'b1, E_FET1, "i_fetch"));
        vecs.push_back(mk(1'b1, OP_II, 1'b1, E_DEC,  "i_decode"));
        vecs.push_back(mk(1'b1, OP_II, 1'b1, E_EXI,  "i_execi"));
        vecs.push_back(mk(1'b1, OP_II, 1'b1, E_AWB,  "i_aluwb"));
        // LUI
        vecs.push_back(mk(1'b1, OP_LU, 1'b1, E_FET1, "lui_fetch"));
        vecs.push_back(mk(1'b1, OP_LU, 1'b1, E_DEC,  "lui_decode"));
        vecs.push_back(mk(1'b1, OP_LU, 1'b1, E_LUI,  "lui_lui"));
        vecs.push_back(mk(1'b1, OP_LU, 1'b1, E_AWB,  "lui_aluwb"));
        // JAL
        vecs.push_back(mk(1'b1, OP_JJ, 1'b1, E_FET1, "jal_fetch"));
        vecs.push_back(mk(1'b1, OP_JJ, 1'b1, E_DEC,  "jal_decode"));
        vecs.push_back(mk(1'b1, OP_JJ, 1'b1, E_JAL,  "jal_jal"));
        vecs.push_back(mk(1'b1, OP_JJ, 1'b1, E_AWB,  "jal_aluwb"));

        foreach (vecs[i]) cyc(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].exp, vecs[i].nm);

        // Asynchronous reset in the middle of a stalled store
        cyc(1'b1, OP_SW, 1'b1, E_FET1, "abort_fetch");
        cyc(1'b1, OP_SW, 1'b1, E_DEC,  "abort_decode");
        cyc(1'b1, OP_SW, 1'b1, E_MADR, "abort_memadr");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_memwrite", E_MWR);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async_strobes", E_RST);
        @(posedge clk);
        #1;
        chk("abort_held_reset", E_RST);
        cyc(1'b1, OP_SW, 1'b0, E_FET0, "abort_back_to_fetch");
        cyc(1'b1, OP_SW, 1'b1, E_FET1, "abort_fetch_again");
        cyc(1'b1, OP_RR, 1'b1, E_DEC,  "abort_decode_r");
        cyc(1'b1, OP_RR, 1'b1, E_EXR,  "abort_execr");
        cyc(1'b1, OP_RR, 1'b1, E_AWB,  "abort_aluwb");

        // Illegal opcode halts; mem_ready must not wake it
        cyc(1'b1, OP_ILL, 1'b1, E_FET1, "ill_fetch");
        cyc(1'b1, OP_ILL, 1'b1, E_DEC,  "ill_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, (i % 2 == 0) ? OP_LW : OP_RR, 1'b1, E_HALT, $sformatf("halt_c%0d", i));
        end
        cyc(1'b0, OP_RR, 1'b1, E_RST,  "halt_reset");
        cyc(1'b1, OP_RR, 1'b0, E_FET0, "halt_exit_fetch");

        // Conditional branch opcode
        cyc(1'b1, OP_BQ, 1'b1, E_FET1, "beq_fetch");
        cyc(1'b1, OP_BQ, 1'b1, E_DEC,  "beq_decode");
`ifdef MC_CTRL_BEQ_EN
        cyc(1'b1, OP_BQ, 1'b1, E_BEQ,  "beq_beq");
        cyc(1'b1, OP_BQ, 1'b0, E_FET0, "beq_back_to_fetch");
`else
        cyc(1'b1, OP_BQ, 1'b1, E_HALT, "beq_illegal_halt");
        cyc(1'b1, OP_BQ, 1'b1, E_HALT, "beq_halt_sticky");
`endif
        cyc(1'b0, OP_RR, 1'b1, E_RST,  "final_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine of the multi-cycle RV32I core.
- Consumes the 7-bit `opcode` produced by the instruction decoder, which sits directly upstream of this block.
- Sequences fetch, decode, execute, memory and writeback.
- Drives datapath mux selects and write strobes, and handshakes with the unified instruction/data memory.

Parameters:
- ILLEGAL_HALT, 1, 1 = an unknown opcode enters sticky HALT; 0 = an unknown opcode returns to FETCH (treated as NOP).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  7  instruction[6:0] from the decoder; sampled only in DECODE and MEMADR
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  store request; qualifies mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register (and OldPC)
- pc_update  out  1  write PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub, 10 = decoded from funct fields
- branch  out  1  conditional-branch strobe; PC loads if ALU zero
- halted  out  1  FSM is in HALT

Behaviour:
- State register is updated on the rising clk edge. Asynchronous reset clears it to FETCH.
- While rst_n is low:
  - all strobes are 0: mem_req, mem_write, ir_write, pc_update, reg_write, branch, halted;
  - selects take their FETCH values.
- Outputs are decoded from state. Exception: ir_write and pc_update in FETCH are gated by mem_ready (Mealy).
- Any select not listed for a state is 00. Any strobe not listed is 0.
- States, outputs and transitions:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (precomputes the branch/jump target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 0110111 -> LUI
    - other -> HALT if ILLEGAL_HALT, else FETCH
  - MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Goes to FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Waits for mem_ready, then goes to FETCH.
  - EXECR: a=10, b=00, alu_op=10. Goes to ALUWB.
  - EXECI: a=10, b=01, alu_op=10. Goes to ALUWB.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB.
  - LUI: a=11, b=01, alu_op=00. Goes to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Goes to FETCH.
  - HALT: halted=1, all strobes 0. Absorbing; only reset exits.
- Latency with a zero-wait memory (mem_ready=1 in the same cycle as the request):
  - R-type, I-type and LUI: 4 cycles
  - JAL: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
  - Each memory wait cycle adds 1.
- mem_req is held with stable adr_src/mem_write until mem_ready. mem_ready while mem_req=0 is ignored.
- Reset asserted mid-instruction aborts it immediately, with no partial writes after the reset edge.
- Unreachable state encodings recover to FETCH.

Optional Feature:
- Macro: MC_CTRL_BEQ_EN
- Defined: opcode 1100011 in DECODE goes to BEQ. BEQ drives a=10, b=00, alu_op=01, result_src=00, branch=1, then goes to FETCH (3 cycles total).
- Undefined: 1100011 is an illegal opcode. The branch port still exists and is tied to 0.

Decomposition:
- Shared package riscv_mc_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_LUI, OP_BRANCH);
  - the state enum;
  - encodings for result_src, alu_src_a, alu_src_b and alu_op.
- No sub-module; next-state and output decode stay in one module.

Test Plan:
- Reset held for 3 cycles, then released with opcode=0110011 and mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in cycle 4; all strobes 0 during reset.
- LW (0000011) with mem_ready low for 2 cycles in MEMREAD -> adr_src=1 and mem_req=1 held 3 cycles; MEMWB has result_src=01 and reg_write=1; total 7 cycles.
- SW (0100011) -> mem_write=1 only in MEMWRITE; reg_write is never asserted; FETCH follows the mem_ready cycle.
- JAL (1101111) -> DECODE a=01/b=01; JAL state pc_update=1, result_src=00; ALUWB reg_write=1.
- Opcode 0001111 with ILLEGAL_HALT=1 -> HALT, halted=1; mem_req stays 0 for 10 cycles; rst_n low returns to FETCH.
- With MC_CTRL_BEQ_EN, opcode 1100011 -> BEQ with branch=1 and alu_op=01; without it -> HALT.
